popcount_frame_accumulator: RTL and testbench
=============================================

// Module: popcount_frame_accumulator
// PURPOSE
//   Downstream consumer of the 7-input popcount stage. Accepts one 3-bit count (0..7) per beat
//   over a valid/ready stream, sums counts across a frame, and emits one registered result per frame
//   (sum, beat count, threshold flag). Frame closes on in_last or after FRAME_LEN beats.
// PARAMETERS
//   FRAME_LEN  16  max beats per frame; frame auto-closes on the FRAME_LEN-th accepted beat
//   SUM_W      8   accumulator/out_sum width; must satisfy 2**SUM_W > 7*FRAME_LEN for exact sums
//   THRESH     56  out_over asserted when final sum > THRESH (unsigned compare)
// PORTS
//   clk        in   1                  single clock, rising edge
//   rst        in   1                  synchronous, active-high reset
//   in_valid   in   1                  upstream beat valid
//   in_ready   out  1                  block can accept a beat
//   in_count   in   3                  popcount from upstream stage, 0..7
//   in_last    in   1                  beat closes the current frame
//   out_valid  out  1                  frame result valid
//   out_ready  in   1                  downstream accepts result
//   out_sum    out  SUM_W              sum of in_count over the frame
//   out_words  out  $clog2(FRAME_LEN+1) number of beats in the frame (1..FRAME_LEN)
//   out_over   out  1                  out_sum > THRESH
//   out_sat    out  1                  sum saturated (see CONFIGURATION)
// BEHAVIOUR
//   - Beat accepted when in_valid && in_ready. in_ready = (state != HOLD), decoded from state only.
//   - FSM: IDLE (no beat yet) -> ACCUM on accepted beat not closing; IDLE/ACCUM -> HOLD on closing
//     beat (in_last=1 or beat count reaches FRAME_LEN); HOLD -> IDLE on out_valid && out_ready.
//   - IDLE accepted beat loads acc=in_count, words=1; ACCUM beat adds: acc+=in_count, words+=1.
//   - Closing beat folded into the result; out_* registered; out_valid=1 the cycle after closing beat
//     (latency 1). out_sum/out_words/out_over/out_sat stable while out_valid && !out_ready.
//   - HOLD: in_ready=0, no beats taken; first new beat accepted the cycle after the result handshake.
//   - Single-beat frame (in_last on first beat) valid: out_words=1, out_sum=in_count.
//   - FRAME_LEN-th beat with in_last=1: one close, no empty follow-on frame.
//   - in_count zero-extended to SUM_W before add; compare for out_over uses final sum.
//   - Reset (any state, incl. mid-frame/HOLD): partial frame discarded; state=IDLE; acc=0, words=0;
//     out_valid=0, out_sum=0, out_words=0, out_over=0, out_sat=0; in_ready=1 first cycle after reset.
// CONFIGURATION
//   Macro POPACC_SATURATE_EN:
//   - defined: accumulator clamps at 2**SUM_W-1; sticky per-frame flag reported on out_sat.
//   - undefined: accumulator wraps modulo 2**SUM_W; out_sat tied 0.
// STRUCTURE
//   - Shared package popcount_pkg: FSM state enum (IDLE, ACCUM, HOLD), COUNT_W=3 constant,
//     MAX_COUNT=7 constant.
//   - One sub-module: popcount_acc_core (load/add/saturate datapath + beat counter); FSM and output
//     registers in top.
// TESTING
//   1. rst mid-frame after 3 beats -> all outputs 0, in_ready=1; next frame sums from 0.
//   2. 4 beats counts 7,7,7,7 with in_last on 4th -> out_valid next cycle, out_sum=28, out_words=4,
//      out_over=0.
//   3. 16 beats of 7, no in_last -> auto-close, out_sum=112, out_words=16, out_over=1.
//   4. out_ready held 0 for 5 cycles -> out_* stable, in_ready=0, upstream beats not consumed.
//   5. SUM_W=6, 10 beats of 7: with POPACC_SATURATE_EN out_sum=63, out_sat=1; without, out_sum=6,
//      out_sat=0.
//   6. single beat count=5 with in_last, out_ready=1 -> out_sum=5, out_words=1; next beat accepted
//      cycle after handshake.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount frame accumulator block.
package popcount_pkg;

  localparam int COUNT_W   = 3;
  localparam int MAX_COUNT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/popcount_frame_accumulator_if.sv
// Beat input stream and frame result stream of the popcount frame accumulator.
interface popcount_frame_accumulator_if #(
  parameter int SUM_W   = 8,
  parameter int WORDS_W = 5
);
  import popcount_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [COUNT_W-1:0] in_count;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [SUM_W-1:0]   out_sum;
  logic [WORDS_W-1:0] out_words;
  logic               out_over;
  logic               out_sat;

  // The accumulator is the slave: it consumes beats and produces frame results.
  modport slave (
    input  in_valid, in_count, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_over, out_sat
  );

  modport master (
    output in_valid, in_count, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_over, out_sat
  );

endinterface

// File: rtl/popcount_acc_core.sv
// Running sum and beat counter for one frame; *_nxt outputs already include the current beat.
// POPACC_SATURATE_EN: clamp the sum at all-ones and keep a sticky per-frame saturation flag.
module popcount_acc_core
  import popcount_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           beat,
  input  logic                           first,
  input  logic [COUNT_W-1:0]             count,
  output logic [SUM_W-1:0]               sum_nxt,
  output logic [$clog2(FRAME_LEN+1)-1:0] words_nxt,
  output logic                           sat_nxt,
  output logic                           full_nxt
);

  localparam int WORDS_W = $clog2(FRAME_LEN + 1);

  logic [SUM_W-1:0]   acc;
  logic [WORDS_W-1:0] words;
  logic [SUM_W-1:0]   base;

  // The first beat of a frame loads rather than adds, so stale state never leaks in.
  always_comb begin
    base      = first ? '0 : acc;
    words_nxt = first ? WORDS_W'(1) : words + WORDS_W'(1);
  end

  assign full_nxt = (words_nxt == WORDS_W'(FRAME_LEN));

`ifdef POPACC_SATURATE_EN
  logic             sat;
  logic [SUM_W:0]   total;

  always_comb begin
    total   = {1'b0, base} + {{(SUM_W + 1 - COUNT_W){1'b0}}, count};
    sum_nxt = total[SUM_W] ? '1 : total[SUM_W-1:0];
    sat_nxt = total[SUM_W] | (sat & ~first);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat <= 1'b0;
    end else if (beat) begin
      sat <= sat_nxt;
    end
  end
`else
  logic [SUM_W-1:0] total;

  always_comb begin
    total   = base + {{(SUM_W - COUNT_W){1'b0}}, count};
    sum_nxt = total;
    sat_nxt = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      words <= '0;
    end else if (beat) begin
      acc   <= sum_nxt;
      words <= words_nxt;
    end
  end

endmodule

// File: rtl/popcount_frame_accumulator.sv
// Sums 3-bit popcounts per frame; one registered result per frame, latency 1 after the closing beat.
// Input stalls (in_ready=0) while a result waits for out_ready. Optional clamp: POPACC_SATURATE_EN.
module popcount_frame_accumulator
  import popcount_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 56
) (
  input logic                          clk,
  input logic                          rst,
  popcount_frame_accumulator_if.slave  bus
);

  localparam int WORDS_W = $clog2(FRAME_LEN + 1);

  state_t             state;
  state_t             state_nxt;
  logic               ready;
  logic               beat;
  logic               first;
  logic               close;
  logic [SUM_W-1:0]   sum_nxt;
  logic [WORDS_W-1:0] words_nxt;
  logic               sat_nxt;
  logic               full_nxt;

  assign beat  = bus.in_valid & ready;
  assign first = (state == IDLE);
  assign close = beat & (bus.in_last | full_nxt);

  popcount_acc_core #(
    .FRAME_LEN (FRAME_LEN),
    .SUM_W     (SUM_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .beat      (beat),
    .first     (first),
    .count     (bus.in_count),
    .sum_nxt   (sum_nxt),
    .words_nxt (words_nxt),
    .sat_nxt   (sat_nxt),
    .full_nxt  (full_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = close ? HOLD : ACCUM;
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state != HOLD);
  end

  assign bus.in_ready = ready;

  // Result fields only change on a closing beat, which cannot occur while HOLD stalls input.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_words <= '0;
      bus.out_over  <= 1'b0;
      bus.out_sat   <= 1'b0;
    end else if (close) begin
      bus.out_valid <= 1'b1;
      bus.out_sum   <= sum_nxt;
      bus.out_words <= words_nxt;
      bus.out_over  <= (32'(sum_nxt) > 32'(THRESH));
      bus.out_sat   <= sat_nxt;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// Directed bench: main instance (SUM_W=8) plus a narrow instance (SUM_W=6) for the overflow case.
module tb_popcount_frame_accumulator;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  popcount_frame_accumulator_if #(.SUM_W(8), .WORDS_W(5)) bus ();
  popcount_frame_accumulator_if #(.SUM_W(6), .WORDS_W(5)) bus6 ();

  popcount_frame_accumulator #(.FRAME_LEN(16), .SUM_W(8), .THRESH(56)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  popcount_frame_accumulator #(.FRAME_LEN(16), .SUM_W(6), .THRESH(56)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int count, input logic last);
    bus.in_valid = 1'b1;
    bus.in_count = 3'(count);
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_count = '0;  bus.in_last = 1'b0;  bus.out_ready = 1'b0;
    bus6.in_valid = 1'b0; bus6.in_count = '0; bus6.in_last = 1'b0; bus6.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_sum",   32'(bus.out_sum),   0);
    chk("reset_words", 32'(bus.out_words), 0);
    chk("reset_ready", 32'(bus.in_ready),  1);

    // Reset mid-frame discards the partial sum.
    send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_sum",   32'(bus.out_sum),   0);
    chk("midrst_words", 32'(bus.out_words), 0);
    chk("midrst_over",  32'(bus.out_over),  0);
    chk("midrst_sat",   32'(bus.out_sat),   0);
    chk("midrst_ready", 32'(bus.in_ready),  1);
    send(1, 1'b0); send(2, 1'b1);
    chk("postrst_valid", 32'(bus.out_valid), 1);
    chk("postrst_sum",   32'(bus.out_sum),   3);
    chk("postrst_words", 32'(bus.out_words), 2);
    handshake();
    chk("postrst_drain", 32'(bus.out_valid), 0);

    // Four sevens closed by in_last.
    send(7, 1'b0); send(7, 1'b0); send(7, 1'b0); send(7, 1'b1);
    chk("f4_valid", 32'(bus.out_valid), 1);
    chk("f4_sum",   32'(bus.out_sum),   28);
    chk("f4_words", 32'(bus.out_words), 4);
    chk("f4_over",  32'(bus.out_over),  0);
    handshake();

    // Sum exactly at threshold is not over.
    for (int i = 0; i < 8; i++) send(7, (i == 7));
    chk("thr_sum",  32'(bus.out_sum),  56);
    chk("thr_over", 32'(bus.out_over), 0);
    handshake();

    // Sixteen sevens without in_last: auto-close.
    for (int i = 0; i < 16; i++) send(7, 1'b0);
    chk("auto_valid", 32'(bus.out_valid), 1);
    chk("auto_sum",   32'(bus.out_sum),   112);
    chk("auto_words", 32'(bus.out_words), 16);
    chk("auto_over",  32'(bus.out_over),  1);
    chk("auto_ready", 32'(bus.in_ready),  0);
    handshake();

    // in_last on the FRAME_LEN-th beat closes once, no empty follow-on frame.
    for (int i = 0; i < 16; i++) send(1, (i == 15));
    chk("lastfull_sum",   32'(bus.out_sum),   16);
    chk("lastfull_words", 32'(bus.out_words), 16);
    handshake();
    tick();
    chk("lastfull_noextra", 32'(bus.out_valid), 0);

    // Backpressure: result held stable, offered beat not consumed until after handshake.
    send(2, 1'b0); send(3, 1'b1);
    bus.in_valid = 1'b1; bus.in_count = 3'd6; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_sum",   32'(bus.out_sum),   5);
      chk("hold_words", 32'(bus.out_words), 2);
      chk("hold_ready", 32'(bus.in_ready),  0);
    end
    handshake();
    chk("hold_release_valid", 32'(bus.out_valid), 0);
    chk("hold_release_ready", 32'(bus.in_ready),  1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("held_beat_sum",   32'(bus.out_sum),   6);
    chk("held_beat_words", 32'(bus.out_words), 1);
    handshake();

    // Single-beat frame with out_ready high; next beat lands the cycle after handshake.
    bus.out_ready = 1'b1;
    send(5, 1'b1);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_sum",   32'(bus.out_sum),   5);
    chk("single_words", 32'(bus.out_words), 1);
    bus.in_valid = 1'b1; bus.in_count = 3'd3; bus.in_last = 1'b1;
    tick();
    chk("single_hs_valid", 32'(bus.out_valid), 0);
    chk("single_hs_ready", 32'(bus.in_ready),  1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("next_valid", 32'(bus.out_valid), 1);
    chk("next_sum",   32'(bus.out_sum),   3);
    tick();
    bus.out_ready = 1'b0;
    chk("next_drain", 32'(bus.out_valid), 0);

    // Narrow accumulator: ten sevens (70) overflow a 6-bit sum.
    for (int i = 0; i < 10; i++) begin
      bus6.in_valid = 1'b1; bus6.in_count = 3'd7; bus6.in_last = (i == 9);
      tick();
    end
    bus6.in_valid = 1'b0; bus6.in_last = 1'b0;
    chk("narrow_valid", 32'(bus6.out_valid), 1);
    chk("narrow_words", 32'(bus6.out_words), 10);
`ifdef POPACC_SATURATE_EN
    chk("narrow_sum", 32'(bus6.out_sum), 63);
    chk("narrow_sat", 32'(bus6.out_sat), 1);
`else
    chk("narrow_sum", 32'(bus6.out_sum), 6);
    chk("narrow_sat", 32'(bus6.out_sat), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
